i2c_reg_sequencer: RTL and testbench

Hardware sequencer that runs complete I2C register transactions on the existing byte-level I2C controller: device address, 8-bit register address, then 1..4 data bytes written, or read back after a repeated start. It drives the controller's trigger/restart/last_byte strobes and waits on its busy flag, so the CPU issues one command instead of polling each byte. It sits between a bus-register front end, or a fixed-function master such as a sensor poller, and i2c_controller.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_phase_timer.sv | 36 +++
 rtl/i2c_reg_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared encodings for the I2C register sequencer and related I2C blocks.
//   phase_e     : which kind of byte phase is being driven on the controller
//   seq_state_e : sequencer FSM states
//   I2C_WRITE / I2C_READ : R/W bit values placed in the address byte
// -----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [1:0] {
        PH_ADDR,
        PH_REG,
        PH_WDATA,
        PH_RDATA
    } phase_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_HIGH,
        ST_WAIT_LOW,
        ST_CHECK,
        ST_FINISH
    } seq_state_e;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_phase_timer.sv
// -----------------------------------------------------------------------------
// i2c_phase_timer
// Loadable down-counter used to bound how long one I2C byte phase may take.
//   clk_i        : clock
//   rst_ni       : synchronous active-low reset
//   load_i       : load load_value_i (takes priority over en_i)
//   load_value_i : cycles remaining minus one
//   en_i         : count down by one (saturates at zero)
//   expired_o    : count has reached zero
// -----------------------------------------------------------------------------
module i2c_phase_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_value_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/i2c_reg_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_reg_sequencer
// Runs a complete I2C register transaction on a byte-level I2C controller:
// device address, register address, then 1..MAX_BYTES data bytes written, or
// read back after a repeated start.
//   clock, reset          : clock, synchronous active-low reset
//   start                 : command strobe, accepted only when idle
//   dev_address, reg_address, rw, length, wdata : command, latched at start
//   rdata, busy, done, error : transaction results/status
//   i2c_trigger, i2c_restart, i2c_last_byte, i2c_address, i2c_read_write,
//   i2c_write_data        : per-phase controls to the controller
//   i2c_read_data, i2c_ack_error, i2c_busy : controller status
// -----------------------------------------------------------------------------
module i2c_reg_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 4,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [6:0]             dev_address,
    input  logic [7:0]             reg_address,
    input  logic                   rw,
    input  logic [2:0]             length,
    input  logic [8*MAX_BYTES-1:0] wdata,
    output logic [8*MAX_BYTES-1:0] rdata,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   i2c_trigger,
    output logic                   i2c_restart,
    output logic                   i2c_last_byte,
    output logic [6:0]             i2c_address,
    output logic                   i2c_read_write,
    output logic [7:0]             i2c_write_data,
    input  logic [7:0]             i2c_read_data,
    input  logic                   i2c_ack_error,
    input  logic                   i2c_busy
);

    localparam int unsigned DW = 8 * MAX_BYTES;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    seq_state_e    state_q;
    phase_e        phase_q;
    logic [6:0]    dev_q;
    logic [7:0]    reg_q;
    logic          rw_q;
    logic [2:0]    len_q;
    logic [DW-1:0] wdata_q;
    logic [2:0]    byte_q;

    logic          len_ok;
    logic          last_data;
    logic [2:0]    byte_nx;
    logic          next_last;
    logic          timer_load;
    logic          timer_en;
    logic          timer_expired;

    assign len_ok    = (length != 3'd0) && ({29'd0, length} <= MAX_BYTES);
    assign last_data = (byte_q == len_q - 3'd1);
    assign byte_nx   = byte_q + 3'd1;
    assign next_last = (byte_nx == len_q - 3'd1);

    // Timer is loaded with TIMEOUT-1 during ISSUE so it reads zero on the
    // TIMEOUT-th wait cycle of the phase.
    assign timer_load = (state_q == ST_ISSUE);
    assign timer_en   = (state_q == ST_WAIT_HIGH) || (state_q == ST_WAIT_LOW);

    i2c_phase_timer #(
        .WIDTH (TW)
    ) u_phase_timer (
        .clk_i        (clock),
        .rst_ni       (reset),
        .load_i       (timer_load),
        .load_value_i (TW'(TIMEOUT - 1)),
        .en_i         (timer_en),
        .expired_o    (timer_expired)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            phase_q        <= PH_ADDR;
            dev_q          <= '0;
            reg_q          <= '0;
            rw_q           <= 1'b0;
            len_q          <= '0;
            wdata_q        <= '0;
            byte_q         <= '0;
            rdata          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            i2c_trigger    <= 1'b0;
            i2c_restart    <= 1'b0;
            i2c_last_byte  <= 1'b0;
            i2c_address    <= '0;
            i2c_read_write <= 1'b0;
            i2c_write_data <= '0;
        end else begin
            i2c_trigger <= 1'b0;
            i2c_restart <= 1'b0;
            done        <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        dev_q   <= dev_address;
                        reg_q   <= reg_address;
                        rw_q    <= rw;
                        len_q   <= length;
                        wdata_q <= wdata;
                        byte_q  <= '0;
                        rdata   <= '0;
                        error   <= 1'b0;
                        if (len_ok) begin
                            busy           <= 1'b1;
                            phase_q        <= PH_ADDR;
                            i2c_address    <= dev_address;
                            i2c_read_write <= I2C_WRITE;
                            i2c_last_byte  <= 1'b0;
                            i2c_write_data <= '0;
                            i2c_trigger    <= 1'b1;
                            i2c_restart    <= 1'b1;
                            state_q        <= ST_ISSUE;
                        end else begin
                            error   <= 1'b1;
                            done    <= 1'b1;
                            state_q <= ST_FINISH;
                        end
                    end
                end

                ST_ISSUE: begin
                    state_q <= ST_WAIT_HIGH;
                end

                ST_WAIT_HIGH: begin
                    if (i2c_busy) begin
                        state_q <= ST_WAIT_LOW;
                    end else if (timer_expired) begin
                        error   <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= ST_FINISH;
                    end
                end

                ST_WAIT_LOW: begin
                    if (!i2c_busy) begin
                        state_q <= ST_CHECK;
                    end else if (timer_expired) begin
                        error   <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= ST_FINISH;
                    end
                end

                ST_CHECK: begin
                    if ((phase_q != PH_RDATA) && i2c_ack_error) begin
                        error   <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= ST_FINISH;
                    end else begin
                        unique case (phase_q)
                            // i2c_read_write distinguishes the initial address
                            // phase from the repeated-start read address phase.
                            PH_ADDR: begin
                                if (i2c_read_write == I2C_READ) begin
                                    phase_q       <= PH_RDATA;
                                    byte_q        <= '0;
                                    i2c_last_byte <= (len_q == 3'd1);
                                end else begin
                                    phase_q        <= PH_REG;
                                    i2c_write_data <= reg_q;
                                    i2c_last_byte  <= 1'b0;
                                end
                                i2c_trigger <= 1'b1;
                                state_q     <= ST_ISSUE;
                            end

                            PH_REG: begin
                                if (rw_q == I2C_READ) begin
                                    phase_q        <= PH_ADDR;
                                    i2c_read_write <= I2C_READ;
                                    i2c_restart    <= 1'b1;
                                end else begin
                                    phase_q        <= PH_WDATA;
                                    byte_q         <= '0;
                                    i2c_write_data <= wdata_q[DW-1 -: 8];
                                    wdata_q        <= wdata_q << 8;
                                    i2c_last_byte  <= (len_q == 3'd1);
                                end
                                i2c_trigger <= 1'b1;
                                state_q     <= ST_ISSUE;
                            end

                            // wdata_q is shifted per byte so the next byte is
                            // always in the top lane.
                            PH_WDATA: begin
                                if (last_data) begin
                                    done    <= 1'b1;
                                    busy    <= 1'b0;
                                    state_q <= ST_FINISH;
                                end else begin
                                    byte_q         <= byte_nx;
                                    i2c_write_data <= wdata_q[DW-1 -: 8];
                                    wdata_q        <= wdata_q << 8;
                                    i2c_last_byte  <= next_last;
                                    i2c_trigger    <= 1'b1;
                                    state_q        <= ST_ISSUE;
                                end
                            end

                            PH_RDATA: begin
                                rdata <= rdata |
                                    ((DW'(i2c_read_data) << (DW - 8)) >> {byte_q, 3'b000});
                                if (last_data) begin
                                    done    <= 1'b1;
                                    busy    <= 1'b0;
                                    state_q <= ST_FINISH;
                                end else begin
                                    byte_q        <= byte_nx;
                                    i2c_last_byte <= next_last;
                                    i2c_trigger   <= 1'b1;
                                    state_q       <= ST_ISSUE;
                                end
                            end

                            default: state_q <= ST_IDLE;
                        endcase
                    end
                end

                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_i2c_reg_sequencer
// Directed bench for i2c_reg_sequencer with a behavioural byte-level
// controller model that logs every trigger.
// -----------------------------------------------------------------------------
module tb_i2c_reg_sequencer;

    localparam int unsigned TO   = 16;
    localparam int          HOLD = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  dev_address = '0;
    logic [7:0]  reg_address = '0;
    logic        rw = 1'b0;
    logic [2:0]  length = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        busy, done, error;
    logic        i2c_trigger, i2c_restart, i2c_last_byte, i2c_read_write;
    logic [6:0]  i2c_address;
    logic [7:0]  i2c_write_data;

    // controller model state
    logic        m_busy  = 1'b0;
    logic        m_ack   = 1'b0;
    logic [7:0]  m_rdata = '0;
    int          hold_cnt = 0;
    int          trig_count = 0;
    int          rd_idx = 0;
    int          nack_idx = -1;
    logic        never_busy = 1'b0;
    logic [7:0]  rd_bytes [0:3];
    logic        log_rs   [0:31];
    logic [6:0]  log_ad   [0:31];
    logic        log_rw   [0:31];
    logic [7:0]  log_wd   [0:31];
    logic        log_lb   [0:31];

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    i2c_reg_sequencer #(
        .MAX_BYTES (4),
        .TIMEOUT   (TO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .dev_address    (dev_address),
        .reg_address    (reg_address),
        .rw             (rw),
        .length         (length),
        .wdata          (wdata),
        .rdata          (rdata),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .i2c_trigger    (i2c_trigger),
        .i2c_restart    (i2c_restart),
        .i2c_last_byte  (i2c_last_byte),
        .i2c_address    (i2c_address),
        .i2c_read_write (i2c_read_write),
        .i2c_write_data (i2c_write_data),
        .i2c_read_data  (m_rdata),
        .i2c_ack_error  (m_ack),
        .i2c_busy       (m_busy)
    );

    // Controller model: busy rises the cycle after trigger and stays high for
    // HOLD cycles; NACK and read data are set up at trigger time.
    always @(posedge clock) begin
        if (!reset) begin
            m_busy   <= 1'b0;
            hold_cnt <= 0;
        end else if (i2c_trigger) begin
            log_rs[trig_count[4:0]] <= i2c_restart;
            log_ad[trig_count[4:0]] <= i2c_address;
            log_rw[trig_count[4:0]] <= i2c_read_write;
            log_wd[trig_count[4:0]] <= i2c_write_data;
            log_lb[trig_count[4:0]] <= i2c_last_byte;
            trig_count <= trig_count + 1;
            m_ack      <= (trig_count == nack_idx);
            if (i2c_restart) begin
                rd_idx <= 0;
            end else if (i2c_read_write) begin
                m_rdata <= rd_bytes[rd_idx[1:0]];
                rd_idx  <= rd_idx + 1;
            end
            if (!never_busy) begin
                m_busy   <= 1'b1;
                hold_cnt <= HOLD;
            end
        end else if (m_busy) begin
            if (hold_cnt <= 1) m_busy <= 1'b0;
            hold_cnt <= hold_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Write data is compared only on phases that transmit it (REG / WDATA).
    task automatic chk_trig(input string tag, input int idx, input logic rs,
                            input logic [6:0] ad, input logic rwb,
                            input logic [7:0] wd, input logic lb);
        logic [17:0] got, exp;
        logic        use_wd;
        use_wd = !rs && !rwb;
        got = {log_rs[idx[4:0]], log_ad[idx[4:0]], log_rw[idx[4:0]],
               (use_wd ? log_wd[idx[4:0]] : 8'h00), log_lb[idx[4:0]]};
        exp = {rs, ad, rwb, (use_wd ? wd : 8'h00), lb};
        check(tag, {14'd0, got}, {14'd0, exp});
    endtask

    task automatic start_cmd(input logic [6:0] d, input logic [7:0] r, input logic rwb,
                             input logic [2:0] len, input logic [31:0] wd);
        dev_address = d;
        reg_address = r;
        rw          = rwb;
        length      = len;
        wdata       = wd;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        if (!done) check({tag, "_done_seen"}, 32'd0, 32'd1);
    endtask

    initial begin
        int base;
        int n;
        int extra;

        // reset state
        reset = 1'b0;
        repeat (3) tick();
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_i2c",   {14'd0, i2c_trigger, i2c_restart, i2c_last_byte,
                            i2c_address, i2c_read_write, i2c_write_data}, 32'd0);
        reset = 1'b1;
        tick();

        // write dev 0x50 reg 0x10 len 2
        base = trig_count;
        start_cmd(7'h50, 8'h10, 1'b0, 3'd2, 32'hA5C3_0000);
        check("wr_busy_rise", {31'd0, busy}, 32'd1);
        wait_done("wr", n);
        check("wr_error", {31'd0, error}, 32'd0);
        check("wr_busy_at_done", {31'd0, busy}, 32'd0);
        check("wr_ntrig", trig_count - base, 32'd4);
        chk_trig("wr_t0", base + 0, 1'b1, 7'h50, 1'b0, 8'h00, 1'b0);
        chk_trig("wr_t1", base + 1, 1'b0, 7'h50, 1'b0, 8'h10, 1'b0);
        chk_trig("wr_t2", base + 2, 1'b0, 7'h50, 1'b0, 8'hA5, 1'b0);
        chk_trig("wr_t3", base + 3, 1'b0, 7'h50, 1'b0, 8'hC3, 1'b1);
        tick();
        check("wr_done_pulse", {31'd0, done}, 32'd0);

        // read dev 0x68 reg 0x3B len 3
        rd_bytes[0] = 8'h12; rd_bytes[1] = 8'h34; rd_bytes[2] = 8'h56; rd_bytes[3] = 8'h78;
        base = trig_count;
        start_cmd(7'h68, 8'h3B, 1'b1, 3'd3, 32'h0);
        wait_done("rd", n);
        check("rd_error", {31'd0, error}, 32'd0);
        check("rd_rdata", rdata, 32'h1234_5600);
        check("rd_ntrig", trig_count - base, 32'd6);
        chk_trig("rd_t0", base + 0, 1'b1, 7'h68, 1'b0, 8'h00, 1'b0);
        chk_trig("rd_t1", base + 1, 1'b0, 7'h68, 1'b0, 8'h3B, 1'b0);
        chk_trig("rd_t2", base + 2, 1'b1, 7'h68, 1'b1, 8'h00, 1'b0);
        chk_trig("rd_t3", base + 3, 1'b0, 7'h68, 1'b1, 8'h00, 1'b0);
        chk_trig("rd_t4", base + 4, 1'b0, 7'h68, 1'b1, 8'h00, 1'b0);
        chk_trig("rd_t5", base + 5, 1'b0, 7'h68, 1'b1, 8'h00, 1'b1);
        tick();

        // NACK on the address phase
        base = trig_count;
        nack_idx = base;
        start_cmd(7'h33, 8'h01, 1'b0, 3'd2, 32'h1122_0000);
        wait_done("nack", n);
        check("nack_error", {31'd0, error}, 32'd1);
        nack_idx = -1;
        repeat (5) tick();
        check("nack_ntrig", trig_count - base, 32'd1);
        check("nack_sticky", {31'd0, error}, 32'd1);
        base = trig_count;
        start_cmd(7'h33, 8'h02, 1'b0, 3'd1, 32'h7E00_0000);
        check("nack_err_clear", {31'd0, error}, 32'd0);
        wait_done("nack_retry", n);
        check("retry_error", {31'd0, error}, 32'd0);
        check("retry_ntrig", trig_count - base, 32'd3);
        chk_trig("retry_t2", base + 2, 1'b0, 7'h33, 1'b0, 8'h7E, 1'b1);
        tick();

        // controller never goes busy: timeout
        never_busy = 1'b1;
        base = trig_count;
        start_cmd(7'h10, 8'h20, 1'b0, 3'd1, 32'h5500_0000);
        check("to_trigger", {31'd0, i2c_trigger}, 32'd1);
        wait_done("to", n);
        check("to_latency", {31'd0, (n >= 16 && n <= 17)}, 32'd1);
        check("to_error", {31'd0, error}, 32'd1);
        repeat (10) tick();
        check("to_ntrig", trig_count - base, 32'd1);
        never_busy = 1'b0;

        // illegal lengths
        base = trig_count;
        start_cmd(7'h11, 8'h22, 1'b0, 3'd0, 32'h0);
        check("len0_done", {31'd0, done}, 32'd1);
        check("len0_error", {31'd0, error}, 32'd1);
        check("len0_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        start_cmd(7'h11, 8'h22, 1'b1, 3'd5, 32'h0);
        check("len5_done", {31'd0, done}, 32'd1);
        check("len5_error", {31'd0, error}, 32'd1);
        repeat (10) tick();
        check("badlen_ntrig", trig_count - base, 32'd0);

        // start while busy is ignored
        base = trig_count;
        start_cmd(7'h44, 8'h55, 1'b0, 3'd1, 32'h9900_0000);
        repeat (2) tick();
        start_cmd(7'h44, 8'h55, 1'b0, 3'd0, 32'h0);
        wait_done("busy_start", n);
        check("busy_start_error", {31'd0, error}, 32'd0);
        extra = 0;
        repeat (30) begin
            tick();
            if (done) extra++;
        end
        check("busy_start_no_2nd_done", extra, 32'd0);
        check("busy_start_ntrig", trig_count - base, 32'd3);

        // reset during WAIT_LOW of a read
        base = trig_count;
        start_cmd(7'h68, 8'h00, 1'b1, 3'd2, 32'h0);
        n = 0;
        while (trig_count < base + 4 && n < 200) begin tick(); n++; end
        check("rst_mid_reach_rdata", {31'd0, trig_count >= base + 4}, 32'd1);
        n = 0;
        while (!m_busy && n < 50) begin tick(); n++; end
        tick();
        reset = 1'b0;
        tick();
        check("rst_mid_busy",  {31'd0, busy},  32'd0);
        check("rst_mid_done",  {31'd0, done},  32'd0);
        check("rst_mid_error", {31'd0, error}, 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        check("rst_mid_i2c",   {14'd0, i2c_trigger, i2c_restart, i2c_last_byte,
                                i2c_address, i2c_read_write, i2c_write_data}, 32'd0);
        reset = 1'b1;
        tick();

        // fresh full-length write after reset
        base = trig_count;
        start_cmd(7'h22, 8'h05, 1'b0, 3'd4, 32'hDEAD_BEEF);
        wait_done("post_rst", n);
        check("post_rst_error", {31'd0, error}, 32'd0);
        check("post_rst_ntrig", trig_count - base, 32'd6);
        chk_trig("post_rst_t2", base + 2, 1'b0, 7'h22, 1'b0, 8'hDE, 1'b0);
        chk_trig("post_rst_t3", base + 3, 1'b0, 7'h22, 1'b0, 8'hAD, 1'b0);
        chk_trig("post_rst_t4", base + 4, 1'b0, 7'h22, 1'b0, 8'hBE, 1'b0);
        chk_trig("post_rst_t5", base + 5, 1'b0, 7'h22, 1'b0, 8'hEF, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
